// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcode constants and helpers for the SRAM responder.
// Byte parity is only used when TL_RESP_PARITY_EN is defined.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Byte lanes touched by an access of 2**size bytes at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addr;
            2'd1:    m = 4'b0011 << addr;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_parity(input logic [31:0] w);
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
    endfunction

endpackage

// File: rtl/tl_ul_sram_responder_if.sv
// TL-UL A/D channel bundle. A fires on a_valid && a_ready, D fires on d_valid && d_ready;
// the sender holds its payload stable while valid is high and ready is low.
interface tl_ul_sram_responder_if #(
    parameter int SOURCE_W = 1
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [29:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                a_corrupt;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic                d_denied;
    logic [31:0]         d_data;
    logic                d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output d_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  d_ready,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
    );

endinterface

// File: rtl/tl_ul_resp_mem.sv
// Byte-writable word array with a registered read port.
// TL_RESP_PARITY_EN adds one even-parity bit per byte, checked on read.
module tl_ul_resp_mem
    import tl_ul_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clock,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rerr
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; only the read register sees new data.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

`ifdef TL_RESP_PARITY_EN
    logic [3:0] par_q [DEPTH_WORDS];
    logic       rerr_q;
    logic [3:0] wpar;

    assign wpar = byte_parity(wdata);

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) par_q[idx][b] <= wpar[b];
            end
        end
        if (re) rerr_q <= |(par_q[idx] ^ byte_parity(mem_q[idx]));
    end

    assign rerr = rerr_q;
`else
    assign rerr = 1'b0;
`endif

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TL-UL manager terminating a 32-bit link into a local word memory through a
// one-entry response slot. Optional byte parity: define TL_RESP_PARITY_EN.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          SOURCE_W    = 1,
    parameter logic [29:0] BASE_ADDR   = 30'h0
) (
    input logic                   clock,
    input logic                   reset,
    tl_ul_sram_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [30:0]         off;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          lanes;
    logic                is_get, is_put, aligned, in_range, mask_ok, legal;
    logic                a_fire, mem_we, mem_re;
    logic [31:0]         mem_rdata;
    logic                mem_rerr;

    logic                d_valid_q,    d_valid_d;
    logic [2:0]          d_opcode_q,   d_opcode_d;
    logic [1:0]          d_size_q,     d_size_d;
    logic [SOURCE_W-1:0] d_source_q,   d_source_d;
    logic                d_denied_q,   d_denied_d;
    logic                d_has_data_q, d_has_data_d;

    // The borrow bit of the offset flags addresses below the window.
    always_comb begin
        off      = {1'b0, bus.a_address} - {1'b0, BASE_ADDR};
        idx      = off[IDX_W+1:2];
        lanes    = lane_mask(bus.a_size, off[1:0]);
        is_get   = (bus.a_opcode == GET);
        is_put   = (bus.a_opcode == PUT_FULL) || (bus.a_opcode == PUT_PARTIAL);
        in_range = !off[30] && (32'(off[29:2]) < 32'(DEPTH_WORDS));
        case (bus.a_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !off[0];
            2'd2:    aligned = (off[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        if (bus.a_opcode == PUT_FULL)         mask_ok = (bus.a_mask == lanes);
        else if (bus.a_opcode == PUT_PARTIAL) mask_ok = ((bus.a_mask & ~lanes) == 4'b0000);
        else                                  mask_ok = 1'b1;
        legal = (is_get || is_put) && (bus.a_param == 3'd0) && (bus.a_size != 2'd3)
                && aligned && in_range && mask_ok;
    end

    assign bus.a_ready = !d_valid_q || bus.d_ready;
    assign a_fire      = bus.a_valid && bus.a_ready;
    assign mem_we      = a_fire && legal && is_put && !bus.a_corrupt;
    assign mem_re      = a_fire && legal && is_get;

    always_comb begin
        d_valid_d    = d_valid_q;
        d_opcode_d   = d_opcode_q;
        d_size_d     = d_size_q;
        d_source_d   = d_source_q;
        d_denied_d   = d_denied_q;
        d_has_data_d = d_has_data_q;
        if (a_fire) begin
            d_valid_d    = 1'b1;
            d_opcode_d   = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size_d     = bus.a_size;
            d_source_d   = bus.a_source;
            d_denied_d   = !legal;
            d_has_data_d = legal && is_get;
        end else if (bus.d_ready) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_valid_q    <= 1'b0;
            d_opcode_q   <= 3'd0;
            d_size_q     <= 2'd0;
            d_source_q   <= '0;
            d_denied_q   <= 1'b0;
            d_has_data_q <= 1'b0;
        end else begin
            d_valid_q    <= d_valid_d;
            d_opcode_q   <= d_opcode_d;
            d_size_q     <= d_size_d;
            d_source_q   <= d_source_d;
            d_denied_q   <= d_denied_d;
            d_has_data_q <= d_has_data_d;
        end
    end

    tl_ul_resp_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx),
        .be    (bus.a_mask),
        .wdata (bus.a_data),
        .rdata (mem_rdata),
        .rerr  (mem_rerr)
    );

    // The read register is not reset, so data and corrupt are qualified by the slot flag.
    assign bus.d_valid   = d_valid_q;
    assign bus.d_opcode  = d_opcode_q;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = d_size_q;
    assign bus.d_source  = d_source_q;
    assign bus.d_sink    = 1'b0;
    assign bus.d_denied  = d_denied_q;
    assign bus.d_data    = d_has_data_q ? mem_rdata : 32'h0;
    assign bus.d_corrupt = d_has_data_q && mem_rerr;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed and randomized bench for tl_ul_sram_responder against a behavioural
// memory model. Honors TL_RESP_PARITY_EN for the parity-corruption step.
module tb_tl_ul_sram_responder;

    localparam int DEPTH  = 256;
    localparam int SW     = 4;
    localparam int BASE_I = 0;

    typedef struct packed {
        logic [2:0]    opcode;
        logic [1:0]    param;
        logic [1:0]    size;
        logic [SW-1:0] source;
        logic          sink;
        logic          denied;
        logic [31:0]   data;
        logic          corrupt;
    } resp_t;

    typedef struct packed {
        logic [2:0]    opcode;
        logic [2:0]    param;
        logic [1:0]    size;
        logic [SW-1:0] source;
        logic [29:0]   address;
        logic [3:0]    mask;
        logic [31:0]   data;
        logic          corrupt;
    } req_t;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tl_ul_sram_responder_if #(.SOURCE_W(SW)) bus ();

    tl_ul_sram_responder #(
        .DEPTH_WORDS (DEPTH),
        .SOURCE_W    (SW),
        .BASE_ADDR   (30'h0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // scoreboard and reference model
    resp_t       exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  ref_bad [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          resp_count = 0;
    int          acc_count = 0;
    int          cyc_count = 0;
    req_t        cur_req;
    logic        cur_valid = 1'b0;
    logic        fix_ready = 1'b1;
    logic        rand_ready = 1'b0;
    logic        accepted = 1'b0;
    logic        stall_prev = 1'b0;
    resp_t       prev_resp;
    resp_t       last_resp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic resp_t obs_resp();
        resp_t o;
        o.opcode  = bus.d_opcode;
        o.param   = bus.d_param;
        o.size    = bus.d_size;
        o.source  = bus.d_source;
        o.sink    = bus.d_sink;
        o.denied  = bus.d_denied;
        o.data    = bus.d_data;
        o.corrupt = bus.d_corrupt;
        return o;
    endfunction

    function automatic logic [3:0] lanes_of(input int bytes, input int ofs);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) m[b] = (b >= ofs) && (b < ofs + bytes);
        return m;
    endfunction

    function automatic req_t mk(input logic [2:0] op, input logic [1:0] size, input logic [29:0] addr,
                                input logic [3:0] mask, input logic [31:0] data, input logic [SW-1:0] src);
        req_t r;
        r = '0;
        r.opcode  = op;
        r.size    = size;
        r.address = addr;
        r.mask    = mask;
        r.data    = data;
        r.source  = src;
        return r;
    endfunction

    // Expected response from the access rules; Put side effects land in ref_mem.
    task automatic model_accept(input req_t r);
        resp_t      e;
        int         addr_i, bytes, ofs, idx;
        logic [3:0] lanes;
        logic       legal;
        addr_i = int'(r.address);
        bytes  = 1 << r.size;
        ofs    = addr_i % 4;
        lanes  = lanes_of(bytes, ofs);
        legal  = (r.opcode == 3'd0 || r.opcode == 3'd1 || r.opcode == 3'd4)
                 && r.param == 3'd0 && r.size != 2'd3 && (addr_i % bytes) == 0
                 && addr_i >= BASE_I && addr_i < BASE_I + DEPTH * 4;
        if (legal && r.opcode == 3'd0 && r.mask != lanes) legal = 1'b0;
        if (legal && r.opcode == 3'd1 && (r.mask & ~lanes) != 4'b0) legal = 1'b0;
        e        = '0;
        e.opcode = (r.opcode == 3'd4) ? 3'd1 : 3'd0;
        e.size   = r.size;
        e.source = r.source;
        e.denied = !legal;
        if (legal) begin
            idx = (addr_i - BASE_I) / 4;
            if (r.opcode == 3'd4) begin
                e.data = ref_mem[idx];
`ifdef TL_RESP_PARITY_EN
                e.corrupt = |ref_bad[idx];
`endif
            end else if (!r.corrupt) begin
                for (int b = 0; b < 4; b++) begin
                    if (r.mask[b]) begin
                        ref_mem[idx][8*b +: 8] = r.data[8*b +: 8];
                        ref_bad[idx][b] = 1'b0;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock: drive at negedge, sample 1ns later, retire/accept in the model.
    task automatic cycle();
        resp_t o, e;
        logic  slot, are;
        @(negedge clock);
        bus.a_valid   = cur_valid;
        bus.a_opcode  = cur_req.opcode;
        bus.a_param   = cur_req.param;
        bus.a_size    = cur_req.size;
        bus.a_source  = cur_req.source;
        bus.a_address = cur_req.address;
        bus.a_mask    = cur_req.mask;
        bus.a_data    = cur_req.data;
        bus.a_corrupt = cur_req.corrupt;
        bus.d_ready   = rand_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
        #1;
        cyc_count++;
        slot = (exp_q.size() != 0);
        are  = !slot || bus.d_ready;
        check("a_ready", 64'(bus.a_ready), 64'(are));
        check("d_valid", 64'(bus.d_valid), 64'(slot));
        o = obs_resp();
        if (stall_prev) check("stall_hold", 64'(o), 64'(prev_resp));
        if (slot && bus.d_ready) begin
            e = exp_q.pop_front();
            check("resp", 64'(o), 64'(e));
            last_resp = o;
            resp_count++;
        end
        stall_prev = slot && !bus.d_ready;
        prev_resp  = o;
        accepted   = cur_valid && are;
        if (accepted) begin
            acc_count++;
            model_accept(cur_req);
        end
    endtask

    task automatic send(input req_t r);
        cur_req   = r;
        cur_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 64 && !accepted; i++) cycle();
        check("send_accept", 64'(accepted), 64'(1));
        cur_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cur_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_random(input logic [SW-1:0] src);
        req_t r;
        int   pick, word, ofs;
        pick = $urandom_range(0, 9);
        r = '0;
        if (pick <= 2)      r.opcode = 3'd0;
        else if (pick <= 4) r.opcode = 3'd1;
        else if (pick <= 8) r.opcode = 3'd4;
        else                r.opcode = 3'($urandom_range(5, 7));
        r.param = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        r.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        word    = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, DEPTH + 4) : $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 7) == 0) ofs = $urandom_range(0, 3);
        else if (r.size == 2'd0)       ofs = $urandom_range(0, 3);
        else if (r.size == 2'd1)       ofs = 2 * $urandom_range(0, 1);
        else                           ofs = 0;
        r.address = 30'(BASE_I + word * 4 + ofs);
        if ($urandom_range(0, 7) == 0) r.mask = 4'($urandom_range(0, 15));
        else if (r.opcode == 3'd1)     r.mask = lanes_of(1 << r.size, ofs) & 4'($urandom_range(0, 15));
        else                           r.mask = lanes_of(1 << r.size, ofs);
        r.data    = $urandom;
        r.source  = src;
        r.corrupt = ($urandom_range(0, 15) == 0);
        send(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_resp, base_cyc;
        cur_req       = '0;
        bus.a_valid   = 1'b0;
        bus.a_opcode  = 3'd0;
        bus.a_param   = 3'd0;
        bus.a_size    = 2'd0;
        bus.a_source  = '0;
        bus.a_address = '0;
        bus.a_mask    = 4'h0;
        bus.a_data    = 32'h0;
        bus.a_corrupt = 1'b0;
        bus.d_ready   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 32'h0;
            ref_bad[i] = 4'h0;
        end

        // reset state
        #1 reset = 1'b1;
        #1;
        check("rst_d_valid", 64'(bus.d_valid), 64'(0));
        check("rst_d_fields", 64'(obs_resp()), 64'(0));
        check("rst_a_ready", 64'(bus.a_ready), 64'(1));
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // fill every word so later reads are defined
        for (int i = 0; i < DEPTH; i++) send(mk(3'd0, 2'd2, 30'(i * 4), 4'hF, $urandom, SW'(i)));
        idle(1);

        // PutFull then Get
        send(mk(3'd0, 2'd2, 30'h10, 4'hF, 32'hDEADBEEF, 4'd1));
        send(mk(3'd4, 2'd2, 30'h10, 4'hF, 32'h0, 4'd2));
        idle(1);
        check("get10_opcode", 64'(last_resp.opcode), 64'(1));
        check("get10_data", 64'(last_resp.data), 64'(32'hDEADBEEF));
        check("get10_denied", 64'(last_resp.denied), 64'(0));
        check("get10_size", 64'(last_resp.size), 64'(2));

        // PutPartial single byte
        send(mk(3'd1, 2'd0, 30'h12, 4'h4, 32'h00AA0000, 4'd3));
        send(mk(3'd4, 2'd2, 30'h10, 4'hF, 32'h0, 4'd4));
        idle(1);
        check("partial_data", 64'(last_resp.data), 64'(32'hDEAABEEF));

        // denied requests
        send(mk(3'd4, 2'd2, 30'h400, 4'hF, 32'h0, 4'd5));
        idle(1);
        check("oob_denied", 64'(last_resp.denied), 64'(1));
        check("oob_data", 64'(last_resp.data), 64'(0));
        send(mk(3'd2, 2'd2, 30'h10, 4'hF, 32'h12345678, 4'd6));
        idle(1);
        check("badop_denied", 64'(last_resp.denied), 64'(1));
        check("badop_opcode", 64'(last_resp.opcode), 64'(0));
        send(mk(3'd4, 2'd2, 30'h11, 4'hF, 32'h0, 4'd7));
        idle(1);
        check("misalign_denied", 64'(last_resp.denied), 64'(1));
        check("misalign_data", 64'(last_resp.data), 64'(0));
        send(mk(3'd4, 2'd2, 30'h3FC, 4'hF, 32'h0, 4'd8));
        idle(1);
        check("lastword_denied", 64'(last_resp.denied), 64'(0));
        send(mk(3'd4, 2'd2, 30'h10, 4'hF, 32'h0, 4'd9));
        idle(1);
        check("unchanged_data", 64'(last_resp.data), 64'(32'hDEAABEEF));

        // back-pressure: one accept while stalled, then a bubble-free burst
        base_acc  = acc_count;
        base_resp = resp_count;
        fix_ready = 1'b0;
        send(mk(3'd4, 2'd2, 30'h10, 4'hF, 32'h0, 4'd1));
        cur_req   = mk(3'd4, 2'd2, 30'h3FC, 4'hF, 32'h0, 4'd2);
        cur_valid = 1'b1;
        repeat (4) cycle();
        check("stall_accepts", 64'(acc_count - base_acc), 64'(1));
        fix_ready = 1'b1;
        base_cyc  = cyc_count;
        send(cur_req);
        for (int s = 3; s < 10; s++) send(mk(3'd4, 2'd2, 30'(s * 4), 4'hF, 32'h0, SW'(s)));
        check("burst_cycles", 64'(cyc_count - base_cyc), 64'(8));
        idle(2);
        check("burst_resps", 64'(resp_count - base_resp), 64'(9));

        // async reset with a response pending; the accepted Put persists
        send(mk(3'd0, 2'd2, 30'h34, 4'hF, 32'h13572468, 4'd3));
        @(posedge clock);
        #2;
        bus.a_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_d_valid", 64'(bus.d_valid), 64'(0));
        check("mid_rst_fields", 64'(obs_resp()), 64'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        send(mk(3'd4, 2'd2, 30'h34, 4'hF, 32'h0, 4'd4));
        idle(1);
        check("persist_data", 64'(last_resp.data), 64'(32'h13572468));

        // parity corruption
        send(mk(3'd0, 2'd2, 30'h20, 4'hF, 32'hA5A50F0F, 4'd5));
        idle(1);
`ifdef TL_RESP_PARITY_EN
        dut.u_mem.par_q[8][0] = ~dut.u_mem.par_q[8][0];
        ref_bad[8][0] = 1'b1;
`endif
        send(mk(3'd4, 2'd2, 30'h20, 4'hF, 32'h0, 4'd6));
        idle(1);
        check("parity_data", 64'(last_resp.data), 64'(32'hA5A50F0F));
`ifdef TL_RESP_PARITY_EN
        check("parity_corrupt", 64'(last_resp.corrupt), 64'(1));
`else
        check("parity_corrupt", 64'(last_resp.corrupt), 64'(0));
`endif
        send(mk(3'd0, 2'd2, 30'h20, 4'hF, 32'hA5A50F0F, 4'd7));

        // randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) send_random(SW'($urandom_range(0, (1 << SW) - 1)));
        rand_ready = 1'b0;
        fix_ready  = 1'b1;
        idle(3);
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (manager end) that sits behind the A/D channel buffer pair and terminates a 32-bit TL-UL link into a local flop-based word memory.
- Accepts Get, PutFullData and PutPartialData on channel A.
- Returns AccessAckData or AccessAck on channel D through a one-entry registered response slot.
- Sustains one request per cycle when D is not back-pressured.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 2..4096.
- SOURCE_W, 1, width of a_source/d_source.
- BASE_ADDR, 30'h0, byte base address; aligned to DEPTH_WORDS*4.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted when high with a_valid
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- a_param  in  3  must be 0
- a_size  in  2  log2 bytes, 0..2
- a_source  in  SOURCE_W  requester tag
- a_address  in  30  byte address
- a_mask  in  4  byte lanes
- a_data  in  32  write data
- a_corrupt  in  1  write data poisoned
- d_valid  out  1  response valid
- d_ready  in  1  response consumed
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  2  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  request rejected
- d_data  out  32  read data; 0 for AccessAck or denied
- d_corrupt  out  1  data poisoned

Behaviour:
Reset and state:
- Asynchronous active-high reset clears d_valid and all d_* registers to 0.
- Memory contents are not reset.

Handshake:
- a_ready = !d_valid || d_ready (combinational).
- Accept fire = a_valid && a_ready.
- Latency: accept at edge N; d_valid is high after edge N, i.e. in cycle N+1.
- d_* fields hold stable while d_valid && !d_ready.
- Back-to-back: d fire and a fire in the same cycle reload the slot with no bubble.
- d_valid deasserts only on d fire with no concurrent a fire.

Legality (any failure sets d_denied=1; no memory write; d_data=0; d_corrupt=0):
- Opcode not in {0,1,4}.
- a_param != 0.
- a_size == 3.
- a_address not aligned to 1<<a_size.
- a_address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4).
- PutFull whose a_mask is not exactly the lanes covered by size/offset.
- PutPartial whose a_mask has bits outside those lanes.

Responses:
- Denied Get returns AccessAckData; denied Put returns AccessAck.
- Index = (a_address - BASE_ADDR) >> 2.
- Legal Put writes masked bytes at the accept edge and responds AccessAck.
- Put with a_corrupt=1 performs no write, responds AccessAck with d_denied=0.
- Legal Get latches the full 32-bit word at the accept edge and responds AccessAckData; byte lanes are not shifted.

Hazards and boundaries:
- A Get accepted the cycle after a Put to the same word returns the new data.
- No same-cycle hazard exists: one access per cycle.
- Last word (index DEPTH_WORDS-1) is legal; the address BASE_ADDR + DEPTH_WORDS*4 is denied.
- Reset asserted mid-transaction drops the pending response; the memory write of an already-accepted Put persists.

Optional Feature:
- TL_RESP_PARITY_EN defined: adds 4 even-parity bits per word, one per byte.
  - Parity is written with each byte on Put.
  - On Get, any parity mismatch sets d_corrupt=1; d_data is returned unmodified.
  - Bytes never written are undefined; the bench must initialise them before reading.
- Undefined: no parity storage; d_corrupt is constantly 0.

Decomposition:
- Package tl_ul_pkg: A opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4), D opcode constants (ACCESS_ACK=0, ACCESS_ACK_DATA=1), and a function lane_mask(size, addr[1:0]).
- Sub-module tl_ul_resp_mem: byte-write word array plus optional parity, with a registered read port.
- Legality checking and the response slot stay in the top module.

Test Plan:
- PutFull addr 0x10, mask 0xF, data 0xDEADBEEF, then Get 0x10 size 2 -> AccessAck, then AccessAckData 0xDEADBEEF, d_denied=0, d_size=2.
- PutPartial addr 0x12 size 0 mask 0x4 data 0x00AA0000, then Get 0x10 -> 0xDEAABEEF.
- Get at BASE+DEPTH_WORDS*4 (0x400), opcode 2, and Get at 0x11 size 2 -> each d_denied=1, d_data=0; memory unchanged.
- d_ready held low 5 cycles with a_valid high -> exactly one accept, a_ready=0, d_* stable.
  - Then d_ready=1 for 8 cycles of requests -> 8 responses, no bubbles, in order, d_source echoed.
- Reset pulse while d_valid=1 -> d_valid=0 asynchronously.
  - A prior Put's data is still readable after reset.
- With TL_RESP_PARITY_EN: force a parity bit flip at 0x20, then Get 0x20 -> d_corrupt=1.
  - Without the macro -> d_corrupt=0.
